idli_sqi_mem_m: RTL and testbench
=================================

// Module: idli_sqi_mem_m
// PURPOSE
//   SQI (quad-SPI) SRAM responder: the memory end of the SQI bus the core initiates on.
//   Decodes READ/WRITE commands from the core's sck/cs/sio and serves a byte array.
//   Used as a synthesisable memory model in the bench; one instance per 4-bit sio lane.
// PARAMETERS
//   ADDR_W  16  byte-address width held; DEPTH = 2**ADDR_W bytes; upper bits of 24b addr ignored
// PORTS
//   i_mem_gck   in   1  system clock; all logic on rising edge
//   i_mem_rst   in   1  synchronous reset, active-high
//   i_mem_sck   in   1  SQI clock from core, sampled on gck
//   i_mem_cs    in   1  chip select, active-low
//   i_mem_sio   in   4  SQI data from core
//   o_mem_sio   out  4  SQI data to core (registered)
//   o_mem_oe    out  1  high while responder drives o_mem_sio (registered)
// BEHAVIOUR
//   Reset (i_mem_rst=1): state IDLE, o_mem_sio=0, o_mem_oe=0, sck_q=0, counters/addr=0;
//     array contents untouched. Reset wins over every other event in the same cycle.
//   Edges: sck_q <= i_mem_sck each gck. rise = i_mem_sck & ~sck_q; fall = ~i_mem_sck & sck_q.
//     Inputs sampled on rise; outputs updated on fall. sck activity with cs=1 ignored.
//   i_mem_cs=1 in any cycle: next state IDLE, o_mem_oe<=0, partial byte discarded.
//   Nibble order: high nibble first for instr, addr and data.
//   States (cs=0; a step = one rise unless noted):
//     IDLE   -> INSTR on first cycle with cs=0 (nothing consumed; the first rise is in INSTR).
//     INSTR  2 rises build 8b instr. 0x03 -> ADDR(rd); 0x02 -> ADDR(wr); else -> IGNORE.
//     ADDR   6 rises build 24b addr; addr reg <= addr[ADDR_W-1:0]. rd -> DUMMY; wr -> WRITE.
//     DUMMY  2 rises (one dummy byte), no output. -> READ.
//     READ   each fall: o_mem_oe<=1, o_mem_sio<=next nibble of mem[addr]; after low nibble
//            addr<=addr+1. First fall after 2nd dummy rise drives high nibble of mem[addr].
//     WRITE  each rise captures a nibble; on 2nd nibble mem[addr]<={hi,lo}, addr<=addr+1.
//     IGNORE absorbs all edges, oe=0, no writes, until cs=1.
//   Address wrap: addr+1 is modulo DEPTH (0xFFFF -> 0x0000 with ADDR_W=16). Sequential mode:
//     no page boundary; burst length unbounded.
//   o_mem_oe low in every state but READ; o_mem_sio holds last value when oe=0.
//   Latency: drive data valid one gck after the sck fall it responds to; core samples on next rise.
//   Requirement on core: sck high and low phases each >= 2 gck cycles.
//   Same-cycle rise and cs deassert: cs wins, nibble dropped.
//   Write-then-read of same address in one transaction impossible (single command per cs).
// TESTING
//   1. WRITE 0x02, addr 0x000010, data 0xAB,0xCD; READ 0x03 addr 0x000010 + dummy ->
//      o_mem_sio nibbles A,B,C,D with oe=1 from first fall after dummy.
//   2. WRITE at 0x00FFFF data 0x11,0x22 -> read 0xFFFF=0x11, 0x0000=0x22 (wrap).
//   3. Preload 0x40=0x5A; WRITE 0x40, one nibble 0xF, then cs=1 -> 0x40 reads 0x5A.
//   4. Instr 0xFF, 10 sck cycles of data 0x3 -> oe stays 0, no array location changes.
//   5. READ in progress, assert i_mem_rst one cycle -> next cycle oe=0, sio=0, state IDLE;
//      new READ after reset returns correct data.
//   6. Toggle sck 8 times with cs=1, then valid READ -> response identical to test 1.

Source files
------------

// File: rtl/idli_sqi_mem_m.sv
// ----------------------------------------------------------------------------
// idli_sqi_mem_m
//   SQI (quad-SPI) SRAM responder. Decodes READ (0x03) and WRITE (0x02)
//   commands that the core sends on sck/cs/sio, and serves a byte array of
//   2**ADDR_W bytes. All nibbles travel high nibble first. One instance
//   serves one 4-bit sio lane.
//
// Parameters
//   ADDR_W     byte-address width held. Upper bits of the 24-bit bus
//              address are ignored. Must be at least 8.
//
// Ports
//   i_mem_gck  in   1  system clock; all logic on its rising edge
//   i_mem_rst  in   1  synchronous reset, active-high
//   i_mem_sck  in   1  SQI clock from the core, oversampled on gck
//   i_mem_cs   in   1  chip select, active-low
//   i_mem_sio  in   4  SQI data from the core
//   o_mem_sio  out  4  SQI data to the core (registered)
//   o_mem_oe   out  1  high while o_mem_sio carries read data (registered)
// ----------------------------------------------------------------------------
module idli_sqi_mem_m #(
    parameter int ADDR_W = 16
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_oe
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } state_t;

    state_t state;
    state_t state_next;

    logic              sck_q;
    logic              rise;
    logic              fall;
    logic [2:0]        cnt;         // nibbles taken so far in the current field
    logic [ADDR_W-5:0] shift;       // instr/addr assembly; older nibbles fall off the top
    logic [ADDR_W-1:0] shift_next;
    logic [7:0]        instr_byte;
    logic              is_read;     // command latched at the end of INSTR
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              phase;       // READ: low nibble next; WRITE: high nibble held
    logic [3:0]        hi;
    logic [7:0]        mem [DEPTH];

    assign rise       = i_mem_sck & ~sck_q;
    assign fall       = ~i_mem_sck & sck_q;
    assign shift_next = {shift, i_mem_sio};
    assign instr_byte = shift_next[7:0];
    assign addr_inc   = addr + ADDR_W'(1);   // wraps modulo DEPTH

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A high cs overrides everything, including a rise
    // seen in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no latch is inferred.
        state_next = state;
        if (i_mem_cs) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = INSTR;
                INSTR: begin
                    if (rise && cnt == 3'd1) begin
                        if (instr_byte == 8'h03 || instr_byte == 8'h02) begin
                            state_next = ADDR;
                        end else begin
                            state_next = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (rise && cnt == 3'd5) begin
                        state_next = is_read ? DUMMY : WRITE;
                    end
                end
                DUMMY: begin
                    if (rise && cnt == 3'd1) begin
                        state_next = READ;
                    end
                end
                default: state_next = state;   // READ, WRITE, IGNORE hold until cs=1
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: edge detect, field assembly, read output, write address.
    // ------------------------------------------------------------------
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sck_q     <= 1'b0;
            o_mem_sio <= 4'h0;
            o_mem_oe  <= 1'b0;
            cnt       <= 3'd0;
            shift     <= '0;
            is_read   <= 1'b0;
            addr      <= '0;
            phase     <= 1'b0;
            hi        <= 4'h0;
        end else begin
            sck_q <= i_mem_sck;
            if (i_mem_cs) begin
                // Deselect: drop any partial field or half-written byte.
                o_mem_oe <= 1'b0;
                cnt      <= 3'd0;
                phase    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= 3'd0;
                        phase <= 1'b0;
                    end
                    INSTR: begin
                        if (rise) begin
                            shift <= shift_next[ADDR_W-5:0];
                            if (cnt == 3'd1) begin
                                cnt     <= 3'd0;
                                is_read <= (instr_byte == 8'h03);
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            shift <= shift_next[ADDR_W-5:0];
                            if (cnt == 3'd5) begin
                                cnt  <= 3'd0;
                                addr <= shift_next;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (rise) begin
                            if (cnt == 3'd1) begin
                                cnt   <= 3'd0;
                                phase <= 1'b0;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    READ: begin
                        // Output changes on the fall so it is settled before the core's next rise.
                        if (fall) begin
                            o_mem_oe  <= 1'b1;
                            o_mem_sio <= phase ? mem[addr][3:0] : mem[addr][7:4];
                            phase     <= ~phase;
                            if (phase) begin
                                addr <= addr_inc;
                            end
                        end
                    end
                    WRITE: begin
                        if (rise) begin
                            phase <= ~phase;
                            if (phase) begin
                                addr <= addr_inc;
                            end else begin
                                hi <= i_mem_sio;
                            end
                        end
                    end
                    default: ;   // IGNORE absorbs every edge
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte array write port; the byte commits on its low nibble.
    // ------------------------------------------------------------------
    always_ff @(posedge i_mem_gck) begin
        // NOTE: the array has no reset; its contents survive i_mem_rst, and resetting it would block RAM inference.
        if (!i_mem_rst && !i_mem_cs && state == WRITE && rise && phase) begin
            mem[addr] <= {hi, i_mem_sio};
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// ----------------------------------------------------------------------------
// tb_idli_sqi_mem_m
//   Drives SQI transactions into idli_sqi_mem_m as the core would, keeps a
//   byte-array model of the memory, and checks every nibble the core samples
//   plus o_mem_oe staying low outside read bursts.
// ----------------------------------------------------------------------------
module tb_idli_sqi_mem_m;

    logic       gck = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs  = 1'b1;
    logic [3:0] sio_in = 4'h0;
    logic [3:0] sio_out;
    logic       oe;

    int tests = 0;
    int fails = 0;

    idli_sqi_mem_m #(.ADDR_W(16)) dut (
        .i_mem_gck (gck),
        .i_mem_rst (rst),
        .i_mem_sck (sck),
        .i_mem_cs  (cs),
        .i_mem_sio (sio_in),
        .o_mem_sio (sio_out),
        .o_mem_oe  (oe)
    );

    always #5 gck = ~gck;

    // Reference: plain byte array plus "has been written" flags.
    byte unsigned model_mem [65536];
    bit           model_vld [65536];

    int         exp_q [$];   // expected nibbles of the current read; -1 = unknown byte
    logic [3:0] cap_q [$];   // nibbles the core sampled
    bit         read_active = 1'b0;
    bit         oe_low      = 1'b0;
    bit         sck_prev    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: the core samples sio on each sck rise during a read burst.
    always @(negedge gck) begin
        int e;
        if (read_active && sck && !sck_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read_overrun: sampled %0h with no expectation", sio_out);
            end else begin
                e = exp_q.pop_front();
                cap_q.push_back(sio_out);
                check("read_oe", oe, 1);
                if (e >= 0) check("read_nibble", sio_out, e[3:0]);
            end
        end
        if (oe_low) check("oe_low", oe, 0);
        sck_prev = sck;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge gck);
            #1;
        end
    endtask

    task automatic nib(input logic [3:0] v);
        int h;
        int l;
        h = $urandom_range(2, 4);
        l = $urandom_range(2, 4);
        sio_in = v;
        sck = 1'b1;
        tick(h);
        sck = 1'b0;
        tick(l);
    endtask

    task automatic send_byte(input logic [7:0] b);
        nib(b[7:4]);
        nib(b[3:0]);
    endtask

    task automatic start();
        oe_low = 1'b1;
        cs = 1'b0;
        tick(2);
    endtask

    task automatic stop();
        read_active = 1'b0;
        oe_low = 1'b0;
        cs = 1'b1;
        tick(1);
        oe_low = 1'b1;
        tick(2);
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [23:0] a);
        send_byte(cmd);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    // Write n bytes from data; if half is set, one extra lone nibble follows.
    task automatic do_write(input logic [23:0] a, input logic [7:0] data [8], input int n, input bit half);
        int m;
        m = a % 65536;
        start();
        send_cmd(8'h02, a);
        for (int i = 0; i < n; i++) begin
            send_byte(data[i]);
            model_mem[m] = data[i];
            model_vld[m] = 1'b1;
            m = (m + 1) % 65536;
        end
        if (half) nib(4'(32'($urandom)));
        stop();
    endtask

    task automatic begin_read(input logic [23:0] a, input int n);
        int m;
        m = a % 65536;
        cap_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (model_vld[m]) begin
                exp_q.push_back(int'(model_mem[m]) >> 4);
                exp_q.push_back(int'(model_mem[m]) & 15);
            end else begin
                exp_q.push_back(-1);
                exp_q.push_back(-1);
            end
            m = (m + 1) % 65536;
        end
        start();
        send_cmd(8'h03, a);
        oe_low = 1'b0;
        nib(4'(32'($urandom)));
        nib(4'(32'($urandom)));
        read_active = 1'b1;
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        begin_read(a, n);
        for (int i = 0; i < 2 * n; i++) nib(4'(32'($urandom)));
        check("read_count", exp_q.size(), 0);
        stop();
    endtask

    // Pin the model with hand-computed nibbles of a 2-byte read.
    task automatic check_cap(input string name, input logic [15:0] lit);
        logic [15:0] got;
        got = 16'hxxxx;
        if (cap_q.size() == 4) got = {cap_q[0], cap_q[1], cap_q[2], cap_q[3]};
        check(name, got, lit);
    endtask

    initial begin
        logic [7:0] d [8];
        logic [23:0] a;
        int n;

        // Reset state.
        tick(3);
        check("reset_oe", oe, 0);
        check("reset_sio", sio_out, 0);
        rst = 1'b0;
        oe_low = 1'b1;
        tick(2);

        // 1. Write AB CD at 0x10, read back.
        d[0] = 8'hAB; d[1] = 8'hCD;
        do_write(24'h000010, d, 2, 1'b0);
        do_read(24'h000010, 2);
        check_cap("t1_abcd", 16'hABCD);

        // 2. Wrap at 0xFFFF.
        d[0] = 8'h11; d[1] = 8'h22;
        do_write(24'h00FFFF, d, 2, 1'b0);
        do_read(24'h00FFFF, 2);
        check_cap("t2_wrap", 16'h1122);

        // 3. Half-written byte is discarded.
        d[0] = 8'h5A; d[1] = 8'h00;
        do_write(24'h000040, d, 1, 1'b0);
        start();
        send_cmd(8'h02, 24'h000040);
        nib(4'hF);
        stop();
        do_read(24'h000040, 2);
        check("t3_keep_5a", {cap_q[0], cap_q[1]}, 8'h5A);

        // 4. Unknown instruction: absorbed, nothing written.
        start();
        send_byte(8'hFF);
        for (int i = 0; i < 10; i++) nib(4'h3);
        stop();
        do_read(24'h000010, 2);
        check_cap("t4_abcd", 16'hABCD);
        do_read(24'h00FFFF, 2);
        do_read(24'h000040, 1);

        // 5. Reset in the middle of a read.
        begin_read(24'h000010, 2);
        nib(4'h0);
        nib(4'h0);
        read_active = 1'b0;
        oe_low = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_oe", oe, 0);
        check("t5_rst_sio", sio_out, 0);
        oe_low = 1'b1;
        cs = 1'b1;
        tick(3);
        do_read(24'h000010, 2);
        check_cap("t5_after_rst", 16'hABCD);

        // 6. sck activity while deselected is ignored.
        for (int i = 0; i < 8; i++) nib(4'(32'($urandom)));
        do_read(24'h000010, 2);
        check_cap("t6_abcd", 16'hABCD);

        // Random traffic in a window straddling the wrap point; upper address byte random.
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
            a = {8'($urandom), 16'((32'hFFF8 + $urandom_range(0, 15)) % 65536)};
            do_write(a, d, n, ($urandom_range(0, 3) == 0));
            a = {8'($urandom), 16'((32'hFFF8 + $urandom_range(0, 15)) % 65536)};
            do_read(a, $urandom_range(1, 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
